// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game control blocks.
// Command bytes are the lower-case ASCII keys; the decoder folds case before comparing.
package pong_pkg;

    localparam logic [7:0] CMD_UP1 = 8'h77;  // 'w'
    localparam logic [7:0] CMD_DN1 = 8'h73;  // 's'
    localparam logic [7:0] CMD_UP2 = 8'h6f;  // 'o'
    localparam logic [7:0] CMD_DN2 = 8'h6c;  // 'l'
    localparam logic [7:0] CMD_RST = 8'h72;  // 'r'

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } rst_state_e;

    // Setting bit 5 maps 'A'..'Z' onto 'a'..'z'
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return b | 8'h20;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte handshake between the UART receiver/transmitter and the command decoder.
interface uart_cmd_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );

endinterface

// File: rtl/btn_hold_timer.sv
// Retriggerable hold timer: active for HOLD_CYCLES cycles after the last load.
module btn_hold_timer #(
    parameter int HOLD_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic active
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Clear wins over load so an opposite key or game reset always drops the level
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = TW'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Turns UART key bytes into held paddle buttons and a timed game reset,
// echoing every accepted command through a one-entry transmit buffer.
module uart_cmd_decoder
    import pong_pkg::*;
#(
    parameter int HOLD_CYCLES = 1250000,
    parameter int RST_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_decoder_if.slave   bus,
    output logic                btn1,
    output logic                btn2,
    output logic                btn3,
    output logic                btn4,
    output logic                game_rst,
    output logic [7:0]          err_cnt
);

    localparam int RW = $clog2(RST_CYCLES + 1);

    rst_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    err_q, err_d;

    logic [7:0]    key;
    logic          rx_live, start_rst, accept, reject, echo_drop;
    logic [3:0]    load, clear, active;

    // Bytes arriving during the reset pulse are invisible to everything below
    always_comb begin
        key       = fold_case(bus.rx_data);
        rx_live   = bus.rx_valid && (state_q == ST_IDLE);
        load[0]   = rx_live && (key == CMD_UP1);
        load[1]   = rx_live && (key == CMD_DN1);
        load[2]   = rx_live && (key == CMD_UP2);
        load[3]   = rx_live && (key == CMD_DN2);
        start_rst = rx_live && (key == CMD_RST);
        accept    = (|load) || start_rst;
        reject    = rx_live && !accept;
        clear[0]  = load[1] || start_rst;
        clear[1]  = load[0] || start_rst;
        clear[2]  = load[3] || start_rst;
        clear[3]  = load[2] || start_rst;
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rst) begin
                    state_d = ST_PULSE;
                    rcnt_d  = RW'(RST_CYCLES);
                end
            end
            ST_PULSE: begin
                if (rcnt_q != '0) begin
                    rcnt_d = rcnt_q - 1'b1;
                end
                if (rcnt_q <= RW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    // A ready transmitter frees the slot in the same cycle a new echo lands
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !bus.tx_ready;
        echo_drop  = 1'b0;
        if (accept) begin
            if (tx_valid_q && !bus.tx_ready) begin
                echo_drop = 1'b1;
            end else begin
                tx_data_d  = bus.rx_data;
                tx_valid_d = 1'b1;
            end
        end
        err_d = err_q;
        if ((reject || echo_drop) && (err_q != 8'hFF)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_timer
        btn_hold_timer #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .load   (load[i]),
            .clear  (clear[i]),
            .active (active[i])
        );
    end

    assign btn1         = active[0] && (state_q == ST_IDLE);
    assign btn2         = active[1] && (state_q == ST_IDLE);
    assign btn3         = active[2] && (state_q == ST_IDLE);
    assign btn4         = active[3] && (state_q == ST_IDLE);
    assign game_rst     = (state_q == ST_PULSE);
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder with HOLD_CYCLES=8, RST_CYCLES=4.
module tb_uart_cmd_decoder;

    localparam int HOLD = 8;
    localparam int RSTC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn1, btn2, btn3, btn4, game_rst;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_cmd_decoder_if bus_if ();

    uart_cmd_decoder #(
        .HOLD_CYCLES(HOLD),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .bus      (bus_if),
        .btn1     (btn1),
        .btn2     (btn2),
        .btn3     (btn3),
        .btn4     (btn4),
        .game_rst (game_rst),
        .err_cnt  (err_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: remaining hold/pulse cycles, echo slot and error tally
    int         m_hold[4];
    int         m_rst;
    bit         m_txv;
    logic [7:0] m_txd;
    int         m_err;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_hold[i] = 0;
        m_rst = 0;
        m_txv = 1'b0;
        m_txd = 8'h00;
        m_err = 0;
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] d, input bit r);
        bit         in_pulse;
        bit         nv;
        logic [7:0] c;
        int         k;
        in_pulse = (m_rst > 0);
        for (int i = 0; i < 4; i++) if (m_hold[i] > 0) m_hold[i]--;
        if (in_pulse) m_rst--;
        nv = m_txv && !r;
        if (v && !in_pulse) begin
            c = d | 8'h20;
            case (c)
                8'h77:   k = 0;
                8'h73:   k = 1;
                8'h6f:   k = 2;
                8'h6c:   k = 3;
                8'h72:   k = 4;
                default: k = -1;
            endcase
            if (k < 0) begin
                if (m_err < 255) m_err++;
            end else begin
                if (k == 4) begin
                    m_rst = RSTC;
                    for (int i = 0; i < 4; i++) m_hold[i] = 0;
                end else begin
                    m_hold[k]     = HOLD;
                    m_hold[k ^ 1] = 0;
                end
                if (m_txv && !r) begin
                    if (m_err < 255) m_err++;
                end else begin
                    m_txd = d;
                    nv    = 1'b1;
                end
            end
        end
        m_txv = nv;
    endfunction

    // Called at posedge+1; applies inputs for the next edge and advances the model
    task automatic step(input bit v, input logic [7:0] d, input bit r);
        bus_if.rx_valid = v;
        bus_if.rx_data  = d;
        bus_if.tx_ready = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
    endtask

    task automatic test_reset();
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({btn1, btn2, btn3, btn4, game_rst, bus_if.tx_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {btn1, btn2, btn3, btn4, game_rst, bus_if.tx_valid});
        end
        checks++;
        if (bus_if.tx_data !== 8'h00 || err_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: tx_data=%h err_cnt=%0d want 00/0", bus_if.tx_data, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        model_edge(1'b0, 8'h00, 1'b0);
        #1;
    endtask

    task automatic test_single_key();
        int high;
        step(1'b1, "w", 1'b0);
        checks++;
        if (btn1 !== 1'b1 || btn2 !== 1'b0) begin
            failures++;
            $display("FAIL single_rise: btn1=%b btn2=%b want 1/0", btn1, btn2);
        end
        checks++;
        if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h77) begin
            failures++;
            $display("FAIL single_echo: tx_valid=%b tx_data=%h want 1/77", bus_if.tx_valid, bus_if.tx_data);
        end
        high = 1;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (btn1 === 1'b1) high++;
        end
        checks++;
        if (high != HOLD) begin
            failures++;
            $display("FAIL single_hold_len: got %0d cycles want %0d", high, HOLD);
        end
        checks++;
        if (bus_if.tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_echo_held: tx_valid=%b want 1", bus_if.tx_valid);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_echo_taken: tx_valid=%b want 0", bus_if.tx_valid);
        end
    endtask

    task automatic test_reload_drop();
        int high;
        int gaps;
        bit fell;
        step(1'b1, "W", 1'b0);
        checks++;
        if (bus_if.tx_data !== 8'h57 || bus_if.tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL reload_echo: tx_data=%h tx_valid=%b want 57/1", bus_if.tx_data, bus_if.tx_valid);
        end
        high = (btn1 === 1'b1) ? 1 : 0;
        gaps = 0;
        fell = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 4) step(1'b1, "w", 1'b0);
            else        step(1'b0, 8'h00, 1'b0);
            if (btn1 === 1'b1) begin
                high++;
                if (fell) gaps++;
            end else begin
                fell = 1'b1;
            end
        end
        checks++;
        if (high != 13 || gaps != 0) begin
            failures++;
            $display("FAIL reload_hold_len: got %0d cycles gaps=%0d want 13/0", high, gaps);
        end
        checks++;
        if (err_cnt !== 8'd1 || bus_if.tx_data !== 8'h57) begin
            failures++;
            $display("FAIL reload_drop: err_cnt=%0d tx_data=%h want 1/57", err_cnt, bus_if.tx_data);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_opposite();
        int both;
        step(1'b1, "w", 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, "s", 1'b1);
        checks++;
        if (btn1 !== 1'b0 || btn2 !== 1'b1) begin
            failures++;
            $display("FAIL opposite_swap: btn1=%b btn2=%b want 0/1", btn1, btn2);
        end
        both = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (btn1 === 1'b1 && btn2 === 1'b1) both++;
        end
        checks++;
        if (both != 0 || btn2 !== 1'b0) begin
            failures++;
            $display("FAIL opposite_tail: both_high=%0d btn2=%b want 0/0", both, btn2);
        end
    endtask

    task automatic test_reset_cmd();
        int g;
        int b3;
        step(1'b1, "r", 1'b1);
        checks++;
        if (game_rst !== 1'b1 || bus_if.tx_data !== 8'h72 || bus_if.tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstcmd_start: game_rst=%b tx_data=%h tx_valid=%b want 1/72/1",
                     game_rst, bus_if.tx_data, bus_if.tx_valid);
        end
        g  = 1;
        b3 = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) step(1'b1, "o", 1'b0);
            else        step(1'b0, 8'h00, 1'b0);
            if (game_rst === 1'b1) g++;
            if (btn3 === 1'b1) b3++;
        end
        checks++;
        if (g != RSTC || b3 != 0) begin
            failures++;
            $display("FAIL rstcmd_pulse: game_rst_cycles=%0d btn3_cycles=%0d want %0d/0", g, b3, RSTC);
        end
        checks++;
        if (err_cnt !== 8'd1 || bus_if.tx_data !== 8'h72) begin
            failures++;
            $display("FAIL rstcmd_ignored: err_cnt=%0d tx_data=%h want 1/72", err_cnt, bus_if.tx_data);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_saturation();
        int act;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'h41, 1'b1);
            if (btn1 || btn2 || btn3 || btn4 || game_rst || bus_if.tx_valid) act++;
        end
        checks++;
        if (err_cnt !== 8'd255 || act != 0) begin
            failures++;
            $display("FAIL saturate: err_cnt=%0d activity=%0d want 255/0", err_cnt, act);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, "l", 1'b0);
        bus_if.rx_valid = 1'b0;
        checks++;
        if (btn4 !== 1'b1 || bus_if.tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: btn4=%b tx_valid=%b want 1/1", btn4, bus_if.tx_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (btn4 !== 1'b0 || bus_if.tx_valid !== 1'b0 || err_cnt !== 8'd0 || bus_if.tx_data !== 8'h00) begin
            failures++;
            $display("FAIL areset_clear: btn4=%b tx_valid=%b err_cnt=%0d tx_data=%h want 0/0/0/00",
                     btn4, bus_if.tx_valid, err_cnt, bus_if.tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        model_edge(1'b0, 8'h00, 1'b0);
        #1;
    endtask

    task automatic test_random();
        logic [7:0] cmds [10];
        logic [7:0] d;
        logic [14:0] got, want;
        bit         v, r;
        int         sel, shown;
        cmds = '{8'h77, 8'h73, 8'h6f, 8'h6c, 8'h57, 8'h53, 8'h4f, 8'h4c, 8'h72, 8'h52};
        shown = 0;
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 8)       d = cmds[sel];
            else if (sel == 8) d = cmds[8 + int'($urandom_range(0, 1))];
            else if (sel < 12) d = 8'($urandom);
            else               d = cmds[int'($urandom_range(0, 7))];
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            step(v, d, r);
            want = {(m_hold[0] > 0 && m_rst == 0), (m_hold[1] > 0 && m_rst == 0),
                    (m_hold[2] > 0 && m_rst == 0), (m_hold[3] > 0 && m_rst == 0),
                    (m_rst > 0), m_txv, m_txd, 1'b0};
            got  = {btn1, btn2, btn3, btn4, game_rst, bus_if.tx_valid, bus_if.tx_data, 1'b0};
            checks++;
            if (got !== want || err_cnt !== 8'(m_err)) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d: got btns/rst/txv/txd=%h err=%0d want %h err=%0d",
                             n, got, err_cnt, want, m_err);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_key();
        test_reload_drop();
        test_opposite();
        test_reset_cmd();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Converts the byte stream from the UART receiver into the four paddle button levels and the game reset consumed by the paddle, ball and score blocks. It sits between the UART byte receiver and the VGA/game top level, replacing raw button wiring. Each key byte produces a timed button hold, emulating a held key. A game-reset command produces a fixed-length reset pulse, and every accepted command is echoed back to the UART transmitter through a one-entry buffer.

## Interface
Parameters:
- HOLD_CYCLES, 1250000: cycles a button stays asserted after its key byte (50 ms at 25 MHz).
- RST_CYCLES, 16: length of the game_rst pulse in cycles.

Ports:
- clk  input  1  system clock, the 25 MHz pixel clock domain.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid when high.
- tx_ready  input  1  transmitter can accept a byte this cycle.
- tx_data  output  8  echo byte.
- tx_valid  output  1  echo byte pending.
- btn1, btn2  output  1 each  player 1 up and down.
- btn3, btn4  output  1 each  player 2 up and down.
- game_rst  output  1  active-high game reset pulse to the game blocks.
- err_cnt  output  8  saturating count of rejected or dropped bytes.

## Operation
- Command bytes (either case is accepted): 'w' → btn1, 's' → btn2, 'o' → btn3, 'l' → btn4, 'r' → game reset. Comparison is done on rx_data with bit 5 forced to 1.
- Button keys:
  - Load that button's hold timer with HOLD_CYCLES, and the button output is high while the timer is non-zero.
  - A repeated byte reloads the timer, so holding a key gives a continuous level.
  - The opposite direction of the same player (btn1/btn2, btn3/btn4) is cleared on the same edge. Both directions of one player are never high together.
- Reset control FSM, states IDLE and PULSE:
  - IDLE → PULSE on an 'r' byte. The counter loads RST_CYCLES, all four timers clear and game_rst goes high.
  - PULSE → IDLE when the counter reaches 1 and decrements to 0.
  - In PULSE, all btn outputs are forced low and every rx byte is ignored: no echo, no err_cnt increment.
- Echo buffer:
  - Each accepted command byte (as received, original case) is written to tx_data and tx_valid is set.
  - tx_valid clears on a cycle with tx_ready high.
  - If a new echo arrives while tx_valid is high and tx_ready is low, the byte is dropped, tx_data is unchanged and err_cnt increments.
  - If tx_ready is high and a new echo arrives in the same cycle, the new byte is loaded and tx_valid stays high.
- Unrecognised byte (in IDLE): no button or reset effect, no echo, err_cnt increments.
- err_cnt saturates at 255. A drop and an unknown byte cannot occur in the same cycle.

## Timing
- Reset values (rst low, asynchronous): all btn low, game_rst low, tx_valid low, tx_data 0x00, err_cnt 0, FSM IDLE, all timers 0.
- Latency: rx_valid at edge N → btn or game_rst high after edge N, i.e. visible in cycle N+1. All outputs are registered.
- Button hold length: high for exactly HOLD_CYCLES cycles after the last reloading byte.
- game_rst is high for exactly RST_CYCLES cycles. It then returns to IDLE, with btn outputs low until the next key.
- The echo byte is visible on tx_data/tx_valid in cycle N+1.
- Reset asserted mid-hold or mid-pulse returns every output to its reset value immediately.
- Timer width is $clog2(HOLD_CYCLES+1). The reset counter width is $clog2(RST_CYCLES+1). Decrements never wrap below 0.

## Structure
- Shared package pong_pkg holds:
  - ASCII command constants CMD_UP1, CMD_DN1, CMD_UP2, CMD_DN2 and CMD_RST (lower-case values).
  - The reset FSM state type.
- Sub-module btn_hold_timer is instantiated four times. Its ports are clk, rst, load, clear and active, and it takes the HOLD_CYCLES parameter.
- The decode logic, FSM, echo buffer and err_cnt live in the top of this block.

## Test plan
All scenarios use HOLD_CYCLES=8 and RST_CYCLES=4.
- Single 'w' strobe → btn1 high for exactly 8 cycles starting in cycle N+1; tx_data=0x77 with tx_valid high until tx_ready.
- 'W', then 'w' again 5 cycles later → btn1 stays high continuously for 13 cycles total. First echo 0x57; the second echo is dropped if tx_ready was held low, giving err_cnt=1.
- 's' while btn1 is active → btn1 low and btn2 high in the same cycle, never both high.
- 'r' followed by 'o' during the pulse → game_rst high 4 cycles, btn3 stays low, only 0x72 is echoed, err_cnt unchanged.
- 300 bytes of 0x41 → no btn activity, no echo, err_cnt=255 (saturated).
- rst pulled low during a btn4 hold and a pending echo → btn4, tx_valid and err_cnt return to 0 immediately, with no clock edge needed.
